// File: rtl/alu_mem_pipe_pkg.sv
// Shared opcode encodings for the ALU + data-RAM pipeline.
package alu_mem_pipe_pkg;

    localparam logic [3:0] OP_ADD     = 4'h0;
    localparam logic [3:0] OP_AND     = 4'h1;
    localparam logic [3:0] OP_OR      = 4'h2;
    localparam logic [3:0] OP_XOR     = 4'h3;
    localparam logic [3:0] OP_SUB     = 4'h4;
    localparam logic [3:0] OP_SLL     = 4'h5;
    localparam logic [3:0] OP_SRL     = 4'h6;
    localparam logic [3:0] OP_SRA     = 4'h7;
    localparam logic [3:0] OP_SLT     = 4'h8;
    localparam logic [3:0] OP_SLTU    = 4'h9;
    localparam logic [3:0] OP_NOTA    = 4'hA;
    localparam logic [3:0] OP_PASSB   = 4'hB;
    localparam logic [3:0] OP_RSV_MIN = 4'hC;

endpackage

// File: rtl/alu_mem_pipe_if.sv
// Issue-side and writeback-side valid/ready bundle for alu_mem_pipe.
interface alu_mem_pipe_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [3:0]        in_op;
    logic [ADDR_W-1:0] in_addr;
    logic              in_we;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_zero;
    logic              out_carry;
    logic              out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, in_addr, in_we, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_carry, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_addr, in_we, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_carry, out_err
    );
endinterface

// File: rtl/alu_mem_pipe_alu_core.sv
// Combinational ALU: a, b, op -> result, carry/borrow, reserved-opcode error.
module alu_mem_pipe_alu_core
    import alu_mem_pipe_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              err
);
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic        [DATA_W:0]   sum;
    logic        [DATA_W:0]   diff;
    logic        [3:0]        sh;

    assign a_s  = a;
    assign b_s  = b;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign sh   = b[3:0];

    // The extra MSB of the widened sum/difference is the carry/borrow.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD:   begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
            OP_SUB:   begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_SLL:   result = a << sh;
            OP_SRL:   result = a >> sh;
            OP_SRA:   result = a_s >>> sh;
            OP_SLT:   result = DATA_W'(a_s < b_s);
            OP_SLTU:  result = DATA_W'(a < b);
            OP_NOTA:  result = ~a;
            OP_PASSB: result = b;
            default:  err = (op >= OP_RSV_MIN);
        endcase
    end
endmodule

// File: rtl/alu_mem_pipe.sv
// Two-stage ALU + sync-read data RAM pipeline (E then O) with valid/ready on both sides.
// Build option: define ALU_MEM_FWD_EN to forward write results into a same-address read instead of stalling.
module alu_mem_pipe
    import alu_mem_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
) (
    input  logic           clk,
    input  logic           rst,
    alu_mem_pipe_if.slave  bus
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              vld_p0;
    logic              we_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [3:0]        op_p0;
    logic [DATA_W-1:0] ram_q_p0;
    logic [DATA_W-1:0] rd_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              zero_p1;
    logic              carry_p1;
    logic              err_p1;

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_err;
    logic [DATA_W-1:0] e_data;
    logic              e_carry;
    logic              e_err;
    logic              pipe_en;
    logic              hazard;
    logic              hazard_stall;
    logic              accept;

    // E drains whenever O can take a new word, so only O back-pressure or a RAW hazard blocks issue.
    assign pipe_en = !vld_p1 | bus.out_ready;
    assign hazard  = bus.in_valid & !bus.in_we & vld_p0 & we_p0 & (addr_p0 == bus.in_addr);
`ifdef ALU_MEM_FWD_EN
    assign hazard_stall = 1'b0;
`else
    assign hazard_stall = hazard;
`endif
    assign bus.in_ready = !rst & pipe_en & !hazard_stall;
    assign accept       = bus.in_valid & bus.in_ready;

    alu_mem_pipe_alu_core #(.DATA_W(DATA_W)) u_alu (
        .a      (a_p0),
        .b      (b_p0),
        .op     (op_p0),
        .result (alu_res),
        .carry  (alu_carry),
        .err    (alu_err)
    );

    // ---- issue -> E ----
    always_ff @(posedge clk) begin
        if (rst)
            vld_p0 <= 1'b0;
        else if (pipe_en)
            vld_p0 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= bus.in_we;
            addr_p0  <= bus.in_addr;
            a_p0     <= bus.in_a;
            b_p0     <= bus.in_b;
            op_p0    <= bus.in_op;
            ram_q_p0 <= mem[bus.in_addr];
        end
    end

`ifdef ALU_MEM_FWD_EN
    logic              fwd_p0;
    logic [DATA_W-1:0] fwd_data_p0;

    always_ff @(posedge clk) begin
        if (accept) begin
            fwd_p0      <= hazard;
            fwd_data_p0 <= alu_res;
        end
    end

    assign rd_p0 = fwd_p0 ? fwd_data_p0 : ram_q_p0;
`else
    assign rd_p0 = ram_q_p0;
`endif

    // Writes commit as the transaction leaves E; reset cancels a pending one.
    always_ff @(posedge clk) begin
        if (!rst && pipe_en && vld_p0 && we_p0)
            mem[addr_p0] <= alu_res;
    end

    always_comb begin
        e_data  = alu_res;
        e_carry = alu_carry;
        e_err   = alu_err;
        if (!we_p0) begin
            e_data  = rd_p0;
            e_carry = 1'b0;
            e_err   = 1'b0;
        end
    end

    // ---- E -> O ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            zero_p1  <= 1'b0;
            carry_p1 <= 1'b0;
            err_p1   <= 1'b0;
        end else if (pipe_en) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                data_p1  <= e_data;
                zero_p1  <= (e_data == '0);
                carry_p1 <= e_carry;
                err_p1   <= e_err;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_zero  = zero_p1;
    assign bus.out_carry = carry_p1;
    assign bus.out_err   = err_p1;
endmodule

// File: tb/tb_alu_mem_pipe.sv
// Directed and randomized checks of alu_mem_pipe against an in-order transaction model.
module tb_alu_mem_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_mem_pipe_if #(.DATA_W(16), .ADDR_W(15)) bus ();

    alu_mem_pipe #(.DATA_W(16), .ADDR_W(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  f;   // {zero, carry, err}
        bit          dc;  // read of a never-written word
    } exp_t;

    exp_t        q[$];
    logic [15:0] mref [int];
    int          total = 0;
    int          bad   = 0;
    bit          acc;
    logic [15:0] last_d;
    logic [2:0]  last_f;
    int          waits;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference ALU written from the opcode table with plain integer arithmetic.
    function automatic exp_t ref_alu(input int a, input int b, input int op);
        exp_t e;
        int   r;
        int   sa;
        int   sb;
        int   sh;
        bit   c;
        bit   er;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        sh = b % 16;
        c  = 0;
        er = 0;
        r  = 0;
        case (op)
            0:  begin r = a + b; c = (r >= 65536); end
            1:  r = a & b;
            2:  r = a | b;
            3:  r = a ^ b;
            4:  begin r = a - b; c = (a < b); end
            5:  r = a * (1 << sh);
            6:  r = a / (1 << sh);
            7:  r = sa >>> sh;
            8:  r = (sa < sb) ? 1 : 0;
            9:  r = (a < b) ? 1 : 0;
            10: r = 65535 - a;
            11: r = b;
            default: begin r = 0; er = 1; end
        endcase
        e.d  = 16'(r & 65535);
        e.f  = {(e.d == 16'h0), c, er};
        e.dc = 0;
        return e;
    endfunction

    task automatic model_accept();
        exp_t e;
        int   ad;
        ad = int'(bus.in_addr);
        if (bus.in_we) begin
            e = ref_alu(int'(bus.in_a), int'(bus.in_b), int'(bus.in_op));
            mref[ad] = e.d;
        end else begin
            e.dc = !mref.exists(ad);
            e.d  = e.dc ? 16'h0 : mref[ad];
            e.f  = {(e.d == 16'h0), 2'b00};
        end
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                last_d = bus.out_data;
                last_f = {bus.out_zero, bus.out_carry, bus.out_err};
                if (e.dc) begin
                    chk("zero_dc", bus.out_zero, 32'(bus.out_data == 16'h0));
                    chk("cf_dc", {bus.out_carry, bus.out_err}, 0);
                end else begin
                    chk("data", bus.out_data, e.d);
                    chk("flags", last_f, e.f);
                end
            end
        end
        if (acc) model_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input logic [14:0] addr, input logic we, output int nwait);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_addr  = addr;
        bus.in_we    = we;
        nwait        = 0;
        acc          = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            step();
            if (!acc) nwait++;
        end
        if (!acc) chk("accept_timeout", acc, 1);
    endtask

    task automatic drain();
        int n;
        bus.in_valid = 1'b0;
        n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        logic [15:0] saved;
        bit          had;
        logic [14:0] atab [9];
        logic [15:0] vtab [4];

        atab = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7, 15'h7FFF};
        vtab = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001};

        bus.in_valid  = 1'b1;
        bus.in_a      = 16'h1;
        bus.in_b      = 16'h2;
        bus.in_op     = 4'h0;
        bus.in_addr   = '0;
        bus.in_we     = 1'b1;
        bus.out_ready = 1'b1;

        // reset: nothing accepted, outputs cleared
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // basic add, read back
        send(16'd1, 16'd0, 4'h0, 15'd0, 1'b1, waits);
        drain();
        chk("add1_data", last_d, 16'd1);
        chk("add1_flags", last_f, 3'b000);
        send(16'd0, 16'd0, 4'h0, 15'd0, 1'b0, waits);
        drain();
        chk("rd0_data", last_d, 16'd1);

        send(16'd10, 16'd15, 4'h1, 15'd5, 1'b1, waits);
        drain();
        chk("and_data", last_d, 16'd10);
        send(16'hFFFF, 16'd1, 4'h0, 15'd6, 1'b1, waits);
        drain();
        chk("addc_data", last_d, 16'd0);
        chk("addc_flags", last_f, 3'b110);

        // write then immediately read the same word
        send(16'd0, 16'h1234, 4'hB, 15'd7, 1'b1, waits);
        send(16'd0, 16'd0, 4'h0, 15'd7, 1'b0, waits);
`ifdef ALU_MEM_FWD_EN
        chk("hazard_bubbles", waits, 0);
`else
        chk("hazard_bubbles", waits, 1);
`endif
        drain();
        chk("hazard_data", last_d, 16'h1234);

        // back-pressure: 3 offered while out_ready is low
        bus.out_ready = 1'b0;
        send(16'd0, 16'h0A01, 4'hB, 15'd1, 1'b1, waits);
        send(16'd0, 16'h0A02, 4'hB, 15'd2, 1'b1, waits);
        bus.in_valid = 1'b1;
        bus.in_b     = 16'h0A03;
        bus.in_addr  = 15'd3;
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_hold_data", bus.out_data, 16'h0A01);
            chk("bp_in_ready", bus.in_ready, 0);
            step();
        end
        bus.out_ready = 1'b1;
        send(16'd0, 16'h0A03, 4'hB, 15'd3, 1'b1, waits);
        drain();
        chk("bp_last_data", last_d, 16'h0A03);
        send(16'd0, 16'd0, 4'h0, 15'd2, 1'b0, waits);
        drain();
        chk("bp_rd2", last_d, 16'h0A02);

        // reserved opcode: result zero, error flag, RAM written with zero
        send(16'd3, 16'd4, 4'hD, 15'd2, 1'b1, waits);
        drain();
        chk("rsv_data", last_d, 16'd0);
        chk("rsv_flags", last_f, 3'b101);
        send(16'd0, 16'd0, 4'h0, 15'd2, 1'b0, waits);
        drain();
        chk("rsv_rd2", last_d, 16'd0);

        // reset while a write sits in E: it must never reach RAM
        had   = mref.exists(2);
        saved = had ? mref[2] : 16'h0;
        send(16'd0, 16'h55AA, 4'hB, 15'd2, 1'b1, waits);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        q.delete();
        if (had) mref[2] = saved;
        send(16'd0, 16'd0, 4'h0, 15'd2, 1'b0, waits);
        drain();
        chk("rst_drop_rd2", last_d, 16'd0);

        // randomized traffic with random back-pressure
        bus.in_valid = 1'b0;
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!bus.in_valid || acc) begin
                if ($urandom_range(0, 4) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_we    = ($urandom_range(0, 9) < 6);
                    bus.in_op    = 4'($urandom_range(0, 15));
                    bus.in_addr  = atab[$urandom_range(0, 8)];
                    bus.in_a     = ($urandom_range(0, 3) == 0) ? vtab[$urandom_range(0, 3)] : 16'($urandom);
                    bus.in_b     = ($urandom_range(0, 3) == 0) ? vtab[$urandom_range(0, 3)] : 16'($urandom);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.out_ready = 1'b1;
        drain();
        chk("final_sb_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
